// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared FIFO mode enum and width helper
package fifo_pkg;

    typedef enum logic {
        FIFO_STD  = 1'b0,
        FIFO_FWFT = 1'b1
    } fifo_mode_e;

    // Bits needed to encode 0..n-1; never less than one bit.
    function automatic int fifo_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - DEPTH x DATA_W dual-port RAM, sync write, async read
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = fifo_width(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_prog.sv
// rtl/fifo_prog.sv - synchronous FIFO with programmable thresholds, flush and STD/FWFT read
module fifo_prog
    import fifo_pkg::*;
#(
    parameter int         DATA_W = 16,
    parameter int         DEPTH  = 8,
    parameter fifo_mode_e MODE   = FIFO_STD,
    parameter int         CNT_W  = fifo_width(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    input  logic [CNT_W-1:0]  af_thresh,
    input  logic [CNT_W-1:0]  ae_thresh,
    output logic [CNT_W-1:0]  level,
    output logic              full,
    output logic              empty,
    output logic              almostfull,
    output logic              almostempty,
    output logic              wr_ack,
    output logic              overflow,
    output logic              underflow
);

    localparam int               PTR_W    = fifo_width(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem_rdata;
    logic              rd_acc;
    logic              wr_acc;

    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
    assign rd_acc = rd_en && !empty && !flush;
    assign wr_acc = wr_en && (!full || rd_acc) && !flush;

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            wr_ack    <= wr_acc;
            overflow  <= wr_en && !wr_acc;
            underflow <= rd_en && empty;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc && rst_n),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    if (MODE == FIFO_FWFT) begin : g_fwft
        assign data_out = mem_rdata;
    end else begin : g_std
        logic [DATA_W-1:0] data_q;
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                data_q <= '0;
            end else if (rd_acc) begin
                data_q <= mem_rdata;
            end
        end
        assign data_out = data_q;
    end

    // Thresholds above DEPTH would otherwise make almostempty track !empty.
    assign almostfull  = (af_thresh != '0) && (level >= af_thresh) && !full;
    assign almostempty = (ae_thresh != '0) && (ae_thresh <= FULL_LVL) && !empty
                         && (level <= ae_thresh);

endmodule

// File: tb/tb_fifo_prog.sv
// tb/tb_fifo_prog.sv - scoreboard bench for fifo_prog in STD (depth 8 and 5) and FWFT modes
module tb_fifo_prog;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Instance a: DEPTH 8, STD
    logic a_flush, a_wr, a_rd, a_full, a_empty, a_af, a_ae, a_ack, a_ovf, a_udf;
    logic [15:0] a_din, a_dout;
    logic [3:0]  a_af_t, a_ae_t, a_level;
    // Instance b: DEPTH 5, STD
    logic b_flush, b_wr, b_rd, b_full, b_empty, b_af, b_ae, b_ack, b_ovf, b_udf;
    logic [15:0] b_din, b_dout;
    logic [2:0]  b_af_t, b_ae_t, b_level;
    // Instance c: DEPTH 8, FWFT
    logic c_flush, c_wr, c_rd, c_full, c_empty, c_af, c_ae, c_ack, c_ovf, c_udf;
    logic [15:0] c_din, c_dout;
    logic [3:0]  c_af_t, c_ae_t, c_level;

    fifo_prog #(.DATA_W(16), .DEPTH(8), .MODE(FIFO_STD)) u_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .wr_en(a_wr), .data_in(a_din),
        .rd_en(a_rd), .data_out(a_dout), .af_thresh(a_af_t), .ae_thresh(a_ae_t),
        .level(a_level), .full(a_full), .empty(a_empty), .almostfull(a_af),
        .almostempty(a_ae), .wr_ack(a_ack), .overflow(a_ovf), .underflow(a_udf));

    fifo_prog #(.DATA_W(16), .DEPTH(5), .MODE(FIFO_STD)) u_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .wr_en(b_wr), .data_in(b_din),
        .rd_en(b_rd), .data_out(b_dout), .af_thresh(b_af_t), .ae_thresh(b_ae_t),
        .level(b_level), .full(b_full), .empty(b_empty), .almostfull(b_af),
        .almostempty(b_ae), .wr_ack(b_ack), .overflow(b_ovf), .underflow(b_udf));

    fifo_prog #(.DATA_W(16), .DEPTH(8), .MODE(FIFO_FWFT)) u_c (
        .clk(clk), .rst_n(rst_n), .flush(c_flush), .wr_en(c_wr), .data_in(c_din),
        .rd_en(c_rd), .data_out(c_dout), .af_thresh(c_af_t), .ae_thresh(c_ae_t),
        .level(c_level), .full(c_full), .empty(c_empty), .almostfull(c_af),
        .almostempty(c_ae), .wr_ack(c_ack), .overflow(c_ovf), .underflow(c_udf));

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboards: stimulus pushes the word a read must return; monitors pop when it lands.
    logic [15:0] a_q [$];
    logic [15:0] b_q [$];
    logic [15:0] b_m [$];
    logic a_chk = 1'b0, b_chk = 1'b0;
    logic a_f, b_f;

    initial forever begin
        @(posedge clk);
        a_f = a_chk;
        #2;
        if (a_f) begin
            if (a_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL a_sb_underrun: got read with no expected word");
            end else begin
                check("a_rdata", int'(a_dout), int'(a_q.pop_front()));
            end
        end
    end

    initial forever begin
        @(posedge clk);
        b_f = b_chk;
        #2;
        if (b_f) begin
            if (b_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL b_sb_underrun: got read with no expected word");
            end else begin
                check("b_rdata", int'(b_dout), int'(b_q.pop_front()));
            end
        end
    end

    initial begin
        int lvl;
        rst_n = 1'b0;
        {a_flush, b_flush, c_flush} = '0;
        {a_wr, a_rd, b_wr, b_rd, c_wr, c_rd} = '1;
        a_din = 16'hDEAD; b_din = 16'hDEAD; c_din = 16'hDEAD;
        a_af_t = 4'd6; a_ae_t = 4'd2;
        b_af_t = 3'd0; b_ae_t = 3'd0;
        c_af_t = 4'd0; c_ae_t = 4'd0;

        // Reset held with both requests asserted
        tick; tick;
        check("rst_level", int'(a_level), 0);
        check("rst_empty", int'(a_empty), 1);
        check("rst_full", int'(a_full), 0);
        check("rst_af", int'(a_af), 0);
        check("rst_ae", int'(a_ae), 0);
        check("rst_ack", int'(a_ack), 0);
        check("rst_ovf", int'(a_ovf), 0);
        check("rst_udf", int'(a_udf), 0);
        check("rst_dout", int'(a_dout), 0);
        check("rst_b_empty", int'(b_empty), 1);
        rst_n = 1'b1;
        {a_wr, a_rd, b_wr, b_rd, c_wr, c_rd} = '0;

        // Fill depth-8 FIFO with 0x11..0x88
        for (int i = 0; i < 8; i++) begin
            a_wr = 1'b1; a_din = 16'((i + 1) * 'h11);
            tick;
            lvl = i + 1;
            check("fill_level", int'(a_level), lvl);
            check("fill_ack", int'(a_ack), 1);
            check("fill_ae", int'(a_ae), int'(lvl >= 1 && lvl <= 2));
            check("fill_af", int'(a_af), int'(lvl >= 6 && lvl <= 7));
            check("fill_full", int'(a_full), int'(lvl == 8));
        end
        a_din = 16'h00EE;
        tick;
        check("ovf_flag", int'(a_ovf), 1);
        check("ovf_ack", int'(a_ack), 0);
        check("ovf_level", int'(a_level), 8);

        // Simultaneous read and write while full
        a_wr = 1'b1; a_din = 16'h0099; a_rd = 1'b1; a_chk = 1'b1; a_q.push_back(16'h0011);
        tick;
        a_wr = 1'b0;
        check("full_rw_level", int'(a_level), 8);
        check("full_rw_ovf", int'(a_ovf), 0);
        check("full_rw_ack", int'(a_ack), 1);
        check("full_rw_full", int'(a_full), 1);
        for (int i = 2; i <= 9; i++) begin
            a_q.push_back(16'(i * 'h11));
            tick;
        end
        a_chk = 1'b0;
        check("drain_empty", int'(a_empty), 1);
        tick;
        a_rd = 1'b0;
        check("empty_rd_udf", int'(a_udf), 1);
        check("empty_rd_level", int'(a_level), 0);
        check("hold_dout", int'(a_dout), 'h99);

        // Flush with a concurrent write
        for (int i = 1; i <= 4; i++) begin
            a_wr = 1'b1; a_din = 16'(i);
            tick;
        end
        check("pre_flush_level", int'(a_level), 4);
        a_flush = 1'b1; a_din = 16'h0077;
        tick;
        a_flush = 1'b0;
        check("flush_level", int'(a_level), 0);
        check("flush_empty", int'(a_empty), 1);
        check("flush_ack", int'(a_ack), 0);
        check("flush_dout_hold", int'(a_dout), 'h99);
        a_din = 16'h0055;
        tick;
        a_wr = 1'b0;
        check("post_flush_ae", int'(a_ae), 1);
        check("post_flush_af", int'(a_af), 0);
        a_ae_t = 4'd0;  #1; check("ae_disabled", int'(a_ae), 0);
        a_ae_t = 4'd15; #1; check("ae_above_depth", int'(a_ae), 0);
        a_ae_t = 4'd1;  #1; check("ae_at_level", int'(a_ae), 1);
        a_af_t = 4'd1;  #1; check("af_at_level", int'(a_af), 1);
        a_rd = 1'b1; a_chk = 1'b1; a_q.push_back(16'h0055);
        tick;
        a_rd = 1'b0; a_chk = 1'b0;
        check("post_flush_empty", int'(a_empty), 1);

        // Depth 5: interleaved traffic across two pointer wraps
        for (int k = 0; k < 2; k++) begin
            b_wr = 1'b1; b_din = 16'hB000 + 16'(k); b_m.push_back(b_din);
            tick;
        end
        for (int k = 2; k < 14; k++) begin
            b_wr = 1'b1; b_din = 16'hB000 + 16'(k); b_rd = 1'b1; b_chk = 1'b1;
            b_q.push_back(b_m.pop_front());
            b_m.push_back(b_din);
            tick;
            check("b_pair_level", int'(b_level), 2);
        end
        b_wr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            b_q.push_back(b_m.pop_front());
            tick;
        end
        b_rd = 1'b0; b_chk = 1'b0;
        check("b_end_empty", int'(b_empty), 1);

        // FWFT behaviour
        c_wr = 1'b1; c_din = 16'h00A5;
        tick;
        c_wr = 1'b0;
        check("fwft_head", int'(c_dout), 'hA5);
        check("fwft_not_empty", int'(c_empty), 0);
        c_rd = 1'b1;
        tick;
        c_rd = 1'b0;
        check("fwft_pop_empty", int'(c_empty), 1);
        check("fwft_pop_udf", int'(c_udf), 0);
        c_rd = 1'b1;
        tick;
        c_rd = 1'b0;
        check("fwft_empty_udf", int'(c_udf), 1);
        c_wr = 1'b1; c_din = 16'h0001;
        tick;
        c_din = 16'h0002;
        tick;
        c_wr = 1'b0;
        check("fwft_head1", int'(c_dout), 1);
        c_rd = 1'b1;
        tick;
        c_rd = 1'b0;
        check("fwft_head2", int'(c_dout), 2);
        check("fwft_level", int'(c_level), 1);

        tick; tick;
        check("a_sb_left", a_q.size(), 0);
        check("b_sb_left", b_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
